// File: rtl/unidad_destino_pipeline_pkg.sv
// Shared types and constants for the destination-tracking pipeline and its load-use detector.
package unidad_destino_pipeline_pkg;

  typedef enum logic {
    NORMAL  = 1'b0,
    BURBUJA = 1'b1
  } estado_t;

  localparam int unsigned REGISTRO_CERO      = 0;
  localparam int unsigned ANCHO_ADDR_DEF     = 5;
  localparam int unsigned ANCHO_CONTADOR_DEF = 16;

endpackage

// File: rtl/detector_load_use.sv
// Raw load-use condition: EX load targets a non-zero register read by the ID instruction.
module detector_load_use
  import unidad_destino_pipeline_pkg::*;
#(
  parameter int unsigned CANT_BITS_ADDR_REGISTROS = ANCHO_ADDR_DEF
) (
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_registro_destino_ex,
  input  logic                                i_reg_write_ex,
  input  logic                                i_mem_read_ex,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
  output logic                                o_load_use
);

  logic w_destino_no_cero;
  logic w_coincide;

  assign w_destino_no_cero = (i_registro_destino_ex != CANT_BITS_ADDR_REGISTROS'(REGISTRO_CERO));
  assign w_coincide        = (i_registro_destino_ex == i_rs_id) | (i_registro_destino_ex == i_rt_id);
  assign o_load_use        = i_mem_read_ex & i_reg_write_ex & w_destino_no_cero & w_coincide;

endmodule

// File: rtl/unidad_destino_pipeline.sv
// EX->MEM->WB destination/write-flag pipeline with load-use stall FSM and saturating bubble counter.
// Optional feature: define DESTINO_ZERO_FILTER_EN to clear write flags targeting register 0.
module unidad_destino_pipeline
  import unidad_destino_pipeline_pkg::*;
#(
  parameter int unsigned CANT_BITS_ADDR_REGISTROS = ANCHO_ADDR_DEF,
  parameter int unsigned CANT_BITS_CONTADOR       = ANCHO_CONTADOR_DEF
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic                                i_flush_ex,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_registro_destino_ex,
  input  logic                                i_reg_write_ex,
  input  logic                                i_mem_read_ex,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
  output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_registro_destino_mem,
  output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_registro_destino_wb,
  output logic                                o_reg_write_mem,
  output logic                                o_reg_write_wb,
  output logic                                o_mem_read_mem,
  output logic                                o_stall,
  output logic [CANT_BITS_CONTADOR-1:0]       o_contador_burbujas
);

  localparam logic [CANT_BITS_CONTADOR-1:0] CONTADOR_MAX = '1;

  logic [CANT_BITS_ADDR_REGISTROS-1:0] r_destino_mem;
  logic [CANT_BITS_ADDR_REGISTROS-1:0] r_destino_wb;
  logic                                r_reg_write_mem;
  logic                                r_reg_write_wb;
  logic                                r_mem_read_mem;
  logic [CANT_BITS_CONTADOR-1:0]       r_contador;
  estado_t                             r_estado;
  estado_t                             w_estado_next;
  logic                                w_load_use;
  logic                                w_stall;
  logic                                w_reg_write_ex;

  detector_load_use #(
    .CANT_BITS_ADDR_REGISTROS(CANT_BITS_ADDR_REGISTROS)
  ) u_detector (
    .i_registro_destino_ex(i_registro_destino_ex),
    .i_reg_write_ex       (i_reg_write_ex),
    .i_mem_read_ex        (i_mem_read_ex),
    .i_rs_id              (i_rs_id),
    .i_rt_id              (i_rt_id),
    .o_load_use           (w_load_use)
  );

`ifdef DESTINO_ZERO_FILTER_EN
  assign w_reg_write_ex = i_reg_write_ex
                        & (i_registro_destino_ex != CANT_BITS_ADDR_REGISTROS'(REGISTRO_CERO));
`else
  assign w_reg_write_ex = i_reg_write_ex;
`endif

  // Stall is also masked during reset so every output reads 0 while it is held.
  always_comb begin
    w_estado_next = r_estado;
    w_stall       = 1'b0;
    case (r_estado)
      NORMAL: begin
        w_stall = w_load_use & ~i_flush_ex & i_enable & ~i_reset;
        if (w_stall) w_estado_next = BURBUJA;
      end
      BURBUJA: begin
        if (i_enable) w_estado_next = NORMAL;
      end
      default: w_estado_next = NORMAL;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_estado <= NORMAL;
    else         r_estado <= w_estado_next;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_destino_mem   <= '0;
      r_destino_wb    <= '0;
      r_reg_write_mem <= 1'b0;
      r_reg_write_wb  <= 1'b0;
      r_mem_read_mem  <= 1'b0;
      r_contador      <= '0;
    end else if (i_enable) begin
      if (i_flush_ex) begin
        r_destino_mem   <= '0;
        r_reg_write_mem <= 1'b0;
        r_mem_read_mem  <= 1'b0;
      end else begin
        r_destino_mem   <= i_registro_destino_ex;
        r_reg_write_mem <= w_reg_write_ex;
        r_mem_read_mem  <= i_mem_read_ex;
      end
      r_destino_wb   <= r_destino_mem;
      r_reg_write_wb <= r_reg_write_mem;
      if (w_stall && (r_contador != CONTADOR_MAX))
        r_contador <= r_contador + CANT_BITS_CONTADOR'(1);
    end
  end

  assign o_registro_destino_mem = r_destino_mem;
  assign o_registro_destino_wb  = r_destino_wb;
  assign o_reg_write_mem        = r_reg_write_mem;
  assign o_reg_write_wb         = r_reg_write_wb;
  assign o_mem_read_mem         = r_mem_read_mem;
  assign o_stall                = w_stall;
  assign o_contador_burbujas    = r_contador;

endmodule

// File: tb/tb_unidad_destino_pipeline.sv
// Scoreboard bench: the driver queues hand-computed expectations, a monitor pops and compares them.
module tb_unidad_destino_pipeline;

  localparam int AW = 5;
  localparam int CW = 2;

`ifdef DESTINO_ZERO_FILTER_EN
  localparam int ZF = 0;
`else
  localparam int ZF = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en, fl, rw, mr;
  logic [AW-1:0] d, rs, rt;
  logic [AW-1:0] dm, dw;
  logic          rwm, rww, mrm, st;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  unidad_destino_pipeline #(
    .CANT_BITS_ADDR_REGISTROS(AW),
    .CANT_BITS_CONTADOR      (CW)
  ) dut (
    .i_clock               (clk),
    .i_reset               (rst),
    .i_enable              (en),
    .i_flush_ex            (fl),
    .i_registro_destino_ex (d),
    .i_reg_write_ex        (rw),
    .i_mem_read_ex         (mr),
    .i_rs_id               (rs),
    .i_rt_id               (rt),
    .o_registro_destino_mem(dm),
    .o_registro_destino_wb (dw),
    .o_reg_write_mem       (rwm),
    .o_reg_write_wb        (rww),
    .o_mem_read_mem        (mrm),
    .o_stall               (st),
    .o_contador_burbujas   (cnt)
  );

  typedef struct {
    string         nombre;
    logic          stall;
    logic [AW-1:0] dm;
    logic          rwm;
    logic          mrm;
    logic [AW-1:0] dw;
    logic          rww;
    logic [CW-1:0] cnt;
  } esperado_t;

  esperado_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string n, input string campo, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", n, campo, act, exp);
    end
  endtask

  task automatic push_exp(input string n, input int e_st, input int e_dm, input int e_rwm, input int e_mrm,
                          input int e_dw, input int e_rww, input int e_cnt);
    esperado_t e;
    e.nombre = n;
    e.stall  = 1'(e_st);
    e.dm     = AW'(e_dm);
    e.rwm    = 1'(e_rwm);
    e.mrm    = 1'(e_mrm);
    e.dw     = AW'(e_dw);
    e.rww    = 1'(e_rww);
    e.cnt    = CW'(e_cnt);
    q.push_back(e);
  endtask

  // One enabled/disabled cycle: drive just after the edge, queue what the outputs must show this cycle.
  task automatic paso(input string n, input int i_en, input int i_fl, input int i_d, input int i_rw,
                      input int i_mr, input int i_rs, input int i_rt,
                      input int e_st, input int e_dm, input int e_rwm, input int e_mrm,
                      input int e_dw, input int e_rww, input int e_cnt);
    @(posedge clk);
    #1;
    en = 1'(i_en); fl = 1'(i_fl); d = AW'(i_d); rw = 1'(i_rw);
    mr = 1'(i_mr); rs = AW'(i_rs); rt = AW'(i_rt);
    push_exp(n, e_st, e_dm, e_rwm, e_mrm, e_dw, e_rww, e_cnt);
  endtask

  task automatic revisar();
    esperado_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nombre, "stall", 32'(st),  32'(e.stall));
      chk(e.nombre, "dm",    32'(dm),  32'(e.dm));
      chk(e.nombre, "rwm",   32'(rwm), 32'(e.rwm));
      chk(e.nombre, "mrm",   32'(mrm), 32'(e.mrm));
      chk(e.nombre, "dw",    32'(dw),  32'(e.dw));
      chk(e.nombre, "rww",   32'(rww), 32'(e.rww));
      chk(e.nombre, "cnt",   32'(cnt), 32'(e.cnt));
      $display("[%0t] %s stall=%0b mem=%0d/%0b/%0b wb=%0d/%0b cnt=%0d",
               $time, e.nombre, st, dm, rwm, mrm, dw, rww, cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3 revisar();
      #4 revisar();
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout pending=%0d required=0", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; fl = 1'b0; d = '0; rw = 1'b0; mr = 1'b0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    //        name                en fl  d rw mr rs rt   st dm rwm mrm dw rww cnt
    paso("reset_state",           1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0,  0);
    paso("pipe_in",               1, 0,  5, 1, 0, 1, 2,  0, 0, 0,  0,  0, 0,  0);
    paso("pipe_mem",              1, 0,  0, 0, 0, 0, 0,  0, 5, 1,  0,  0, 0,  0);
    paso("pipe_wb",               1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  5, 1,  0);
    paso("lu_stall",              1, 0,  8, 1, 1, 8, 3,  1, 0, 0,  0,  0, 0,  0);
    paso("lu_burbuja",            1, 0,  8, 1, 1, 8, 3,  0, 8, 1,  1,  0, 0,  1);
    paso("lu_normal",             1, 0,  0, 0, 0, 0, 0,  0, 8, 1,  1,  8, 1,  1);
    paso("flush_hazard",          1, 1,  8, 1, 1, 3, 8,  0, 0, 0,  0,  8, 1,  1);
    paso("flush_mem",             1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0,  1);
    paso("no_match",              1, 0,  9, 1, 1, 1, 2,  0, 0, 0,  0,  0, 0,  1);
    paso("dest_zero_ld",          1, 0,  0, 1, 1, 0, 0,  0, 9, 1,  1,  0, 0,  1);
    paso("zero_mem",              1, 0, 12, 1, 0, 0, 0,  0, 0, ZF, 1,  9, 1,  1);
    paso("freeze1",               0, 0,  4, 1, 1, 4, 0,  0,12, 1,  0,  0, ZF, 1);
    paso("freeze2",               0, 0,  7, 1, 0, 1, 1,  0,12, 1,  0,  0, ZF, 1);
    paso("freeze3",               0, 1,  6, 1, 1, 6, 6,  0,12, 1,  0,  0, ZF, 1);
    paso("thaw",                  1, 0,  0, 0, 0, 0, 0,  0,12, 1,  0,  0, ZF, 1);
    paso("sat_stall1",            1, 0, 10, 1, 1,10, 0,  1, 0, 0,  0, 12, 1,  1);
    paso("sat_burb1",             1, 0,  0, 0, 0, 0, 0,  0,10, 1,  1,  0, 0,  2);
    paso("sat_stall2",            1, 0, 11, 1, 1, 0,11,  1, 0, 0,  0, 10, 1,  2);
    paso("sat_burb2",             1, 0,  0, 0, 0, 0, 0,  0,11, 1,  1,  0, 0,  3);
    paso("sat_stall3",            1, 0, 13, 1, 1,13,13,  1, 0, 0,  0, 11, 1,  3);
    paso("sat_hold",              1, 0,  0, 0, 0, 0, 0,  0,13, 1,  1,  0, 0,  3);
    paso("sat_stall4",            1, 0, 14, 1, 1,14, 0,  1, 0, 0,  0, 13, 1,  3);
    paso("pre_reset_burbuja",     1, 0,  0, 0, 0, 0, 0,  0,14, 1,  1,  0, 0,  3);
    // Mid-cycle asynchronous reset while in BURBUJA, with a live hazard on the inputs.
    #4;
    d = 5'd3; rw = 1'b1; mr = 1'b1; rs = 5'd3;
    rst = 1'b1;
    push_exp("reset_async", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    d = '0; rw = 1'b0; mr = 1'b0; rs = '0;
    rst = 1'b0;
    paso("post_reset_stall",      1, 0, 15, 1, 1, 0,15,  1, 0, 0,  0,  0, 0,  0);
    paso("post_reset_cnt",        1, 0,  0, 0, 0, 0, 0,  0,15, 1,  1,  0, 0,  1);
    @(posedge clk);
    #8;
    chk("scoreboard", "pending", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_destino_pipeline.md
# unidad_destino_pipeline

Producer end of the forwarding interface: carries each instruction's destination register and write-control bits from EX through MEM and WB, and publishes the MEM/WB destination and reg-write values that the forwarding logic compares against EX source operands. It also detects load-use hazards, which forwarding cannot cover, and requests a one-cycle stall with bubble insertion. It sits between the EX stage and the MEM/WB pipeline registers of the MIPS core, under control of the debug unit's step enable.

## Interface
Parameters:
- CANT_BITS_ADDR_REGISTROS, 5, register address width
- CANT_BITS_CONTADOR, 16, bubble counter width

Ports:
- i_clock  in  1  core clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  pipeline advance enable (debug step); 0 freezes all state
- i_flush_ex  in  1  squash instruction leaving EX (taken branch/jump)
- i_registro_destino_ex  in  CANT_BITS_ADDR_REGISTROS  destination register of EX instruction
- i_reg_write_ex  in  1  EX instruction writes register file
- i_mem_read_ex  in  1  EX instruction is a load
- i_rs_id, i_rt_id  in  CANT_BITS_ADDR_REGISTROS each  source registers of ID instruction
- o_registro_destino_mem, o_registro_destino_wb  out  CANT_BITS_ADDR_REGISTROS each  destination in MEM / WB
- o_reg_write_mem, o_reg_write_wb  out  1 each  write flags in MEM / WB
- o_mem_read_mem  out  1  MEM instruction is a load
- o_stall  out  1  hold PC and IF/ID, bubble ID/EX
- o_contador_burbujas  out  CANT_BITS_CONTADOR  saturating count of bubbles inserted

## Operation
- Reset (async, any time): all outputs 0, FSM to NORMAL, counter 0. Reset mid-stall aborts the stall immediately.
- Pipeline: on each rising edge with i_enable=1, EX fields load into MEM, and MEM fields load into WB. With i_flush_ex=1, MEM receives reg_write=0, mem_read=0, destino=0.
- Load-use condition: i_mem_read_ex & i_reg_write_ex & (i_registro_destino_ex != 0) & (destino_ex == i_rs_id | destino_ex == i_rt_id).
- FSM states:
  - NORMAL: o_stall = condition & ~i_flush_ex & i_enable. If o_stall=1 at an enabled edge, go to BURBUJA and increment the counter, saturating at all-ones.
  - BURBUJA: o_stall=0. The bubble now in EX has reg_write=0, so the condition cannot re-fire for the same pair. Next enabled edge returns to NORMAL.
- Simultaneous events:
  - Flush and hazard in the same cycle: flush wins; no stall, no count.
  - i_enable=0: state, counter and pipeline fields hold, and o_stall=0.
- Destination 0 is tracked like any register unless the Configuration macro is defined.

## Timing
- Latency: EX inputs appear on MEM outputs 1 cycle later and on WB outputs 2 cycles later (enabled edges only).
- o_stall is combinational from current inputs and state; it is valid in the same cycle as the hazard. External logic samples it at the same edge.
- A load-use pair produces exactly one stall cycle. The dependent instruction then reaches EX while the load is in WB, and forwarding from WB resolves it.
- All MEM/WB outputs are registered, with no combinational path from inputs.

## Configuration
- DESTINO_ZERO_FILTER_EN:
  - Defined: a write flag whose destination is register 0 is cleared when loaded into MEM, so o_reg_write_mem and o_reg_write_wb are never 1 with destino 0. This prevents false forwarding of $zero.
  - Undefined: flags pass unmodified, and only the load-use check excludes register 0.

## Structure
- Shared package holds: FSM state encoding (NORMAL=0, BURBUJA=1), REGISTRO_CERO constant, default widths.
- One sub-module, detector_load_use: combinational comparator producing the raw load-use condition, reusable by the hazard unit.
- Top level holds: MEM/WB registers, FSM, saturating counter.

## Test plan
- Reset: assert i_reset mid-BURBUJA -> all outputs 0 and FSM NORMAL asynchronously, before the next edge.
- Plain pipeline: EX destino=5, reg_write=1 -> o_registro_destino_mem=5 after 1 edge, o_registro_destino_wb=5 after 2 edges, both flags 1.
- Load-use: EX load into 8, ID rs=8 -> o_stall=1 for exactly one cycle, counter=1, o_mem_read_mem=1 next cycle; second cycle o_stall=0.
- Flush priority: same as the load-use case plus i_flush_ex=1 -> o_stall=0, counter stays 0, MEM gets reg_write=0 and destino=0.
- Enable freeze: i_enable=0 for 3 cycles with changing EX inputs -> MEM/WB outputs, state and counter unchanged, o_stall=0.
- Zero filter (macro defined): EX destino=0, reg_write=1 -> o_reg_write_mem=0; without the macro -> 1. Counter saturation: preload near max, 2 stalls -> holds at all-ones.
